ex_level: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline.
- Consumes the ID/EX pipeline registers and forwards operands from MEM and WB.
- Computes ALU results and memory addresses.
- Owns the multi-cycle multiply/divide unit (MDU) with its HI/LO registers, and drives the EX/MEM pipeline registers plus the EX forwarding pair back to ID.

---
 rtl/ex_level_if.sv | 114 +++++++++++
 rtl/ex_level.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ex_level.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_level_if.sv
// EX-stage bus: shared instruction ids and widths, plus the ID/EX -> EX/MEM interface.
// Optional feature macro used by ex_level: MDU_MADD_EN.

`ifndef WIDTH_INSTR
`define WIDTH_INSTR 6
`endif
`ifndef WIDTH_T
`define WIDTH_T 2
`endif

package ex_level_pkg;
  localparam int unsigned W_INSTR = `WIDTH_INSTR;
  localparam int unsigned W_T     = `WIDTH_T;

  typedef logic [`WIDTH_INSTR-1:0] instr_t;

  localparam instr_t I_NOP   = instr_t'(0);
  localparam instr_t I_ADD   = instr_t'(1);
  localparam instr_t I_ADDU  = instr_t'(2);
  localparam instr_t I_SUB   = instr_t'(3);
  localparam instr_t I_SUBU  = instr_t'(4);
  localparam instr_t I_AND   = instr_t'(5);
  localparam instr_t I_OR    = instr_t'(6);
  localparam instr_t I_XOR   = instr_t'(7);
  localparam instr_t I_NOR   = instr_t'(8);
  localparam instr_t I_SLT   = instr_t'(9);
  localparam instr_t I_SLTU  = instr_t'(10);
  localparam instr_t I_SLL   = instr_t'(11);
  localparam instr_t I_SRL   = instr_t'(12);
  localparam instr_t I_SRA   = instr_t'(13);
  localparam instr_t I_SLLV  = instr_t'(14);
  localparam instr_t I_SRLV  = instr_t'(15);
  localparam instr_t I_SRAV  = instr_t'(16);
  localparam instr_t I_ADDI  = instr_t'(17);
  localparam instr_t I_ADDIU = instr_t'(18);
  localparam instr_t I_SLTI  = instr_t'(19);
  localparam instr_t I_SLTIU = instr_t'(20);
  localparam instr_t I_ANDI  = instr_t'(21);
  localparam instr_t I_ORI   = instr_t'(22);
  localparam instr_t I_XORI  = instr_t'(23);
  localparam instr_t I_LUI   = instr_t'(24);
  localparam instr_t I_LW    = instr_t'(25);
  localparam instr_t I_LH    = instr_t'(26);
  localparam instr_t I_LHU   = instr_t'(27);
  localparam instr_t I_LB    = instr_t'(28);
  localparam instr_t I_LBU   = instr_t'(29);
  localparam instr_t I_SW    = instr_t'(30);
  localparam instr_t I_SH    = instr_t'(31);
  localparam instr_t I_SB    = instr_t'(32);
  localparam instr_t I_MULT  = instr_t'(33);
  localparam instr_t I_MULTU = instr_t'(34);
  localparam instr_t I_DIV   = instr_t'(35);
  localparam instr_t I_DIVU  = instr_t'(36);
  localparam instr_t I_MFHI  = instr_t'(37);
  localparam instr_t I_MFLO  = instr_t'(38);
  localparam instr_t I_MTHI  = instr_t'(39);
  localparam instr_t I_MTLO  = instr_t'(40);
  localparam instr_t I_MADD  = instr_t'(41);
  localparam instr_t I_MADDU = instr_t'(42);
  localparam instr_t I_MSUB  = instr_t'(43);
  localparam instr_t I_MSUBU = instr_t'(44);
  localparam instr_t I_JAL   = instr_t'(45);
  localparam instr_t I_JALR  = instr_t'(46);
  localparam instr_t I_MOVZ  = instr_t'(47);
  localparam instr_t I_MOVN  = instr_t'(48);
endpackage

interface ex_level_if;
  import ex_level_pkg::*;

  logic                  clr;
  instr_t                instr_EX;
  logic [31:0]           PC_EX;
  logic [31:0]           dataRs_EX;
  logic [31:0]           dataRt_EX;
  logic [15:0]           imm16_EX;
  logic [4:0]            shamt_EX;
  logic [4:0]            addrRs_EX;
  logic [4:0]            addrRt_EX;
  logic [4:0]            regWriteAddr_EX;
  logic [31:0]           regWriteData_EX;
  logic [`WIDTH_T-1:0]   Tnew_EX;
  logic [4:0]            regaddr_MEM;
  logic [4:0]            regaddr_WB;
  logic [31:0]           regdata_MEM;
  logic [31:0]           regdata_WB;

  logic [4:0]            regaddr_EXfwd;
  logic [31:0]           regdata_EXfwd;
  logic                  mdu_busy;
  instr_t                instr_MEM;
  logic [31:0]           PC_MEM;
  logic [31:0]           aluOut_MEM;
  logic [31:0]           dataRt_MEM;
  logic [4:0]            regWriteAddr_MEM;
  logic [31:0]           regWriteData_MEM;
  logic [`WIDTH_T-1:0]   Tnew_MEM;

  modport slave (
    input  clr, instr_EX, PC_EX, dataRs_EX, dataRt_EX, imm16_EX, shamt_EX,
           addrRs_EX, addrRt_EX, regWriteAddr_EX, regWriteData_EX, Tnew_EX,
           regaddr_MEM, regaddr_WB, regdata_MEM, regdata_WB,
    output regaddr_EXfwd, regdata_EXfwd, mdu_busy, instr_MEM, PC_MEM,
           aluOut_MEM, dataRt_MEM, regWriteAddr_MEM, regWriteData_MEM, Tnew_MEM
  );

  modport master (
    output clr, instr_EX, PC_EX, dataRs_EX, dataRt_EX, imm16_EX, shamt_EX,
           addrRs_EX, addrRt_EX, regWriteAddr_EX, regWriteData_EX, Tnew_EX,
           regaddr_MEM, regaddr_WB, regdata_MEM, regdata_WB,
    input  regaddr_EXfwd, regdata_EXfwd, mdu_busy, instr_MEM, PC_MEM,
           aluOut_MEM, dataRt_MEM, regWriteAddr_MEM, regWriteData_MEM, Tnew_MEM
  );
endinterface

// File: rtl/ex_level.sv
// MIPS execute stage: operand forwarding, ALU, multi-cycle MDU with HI/LO, EX/MEM register.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU accumulate into HI/LO).

`ifndef WIDTH_INSTR
`define WIDTH_INSTR 6
`endif
`ifndef WIDTH_T
`define WIDTH_T 2
`endif

module ex_level
  import ex_level_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  ex_level_if.slave  bus
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;
  typedef enum logic [2:0] {
    M_MULT, M_MULTU, M_DIV, M_DIVU, M_MADD, M_MADDU, M_MSUB, M_MSUBU
  } mdu_op_e;

  logic [31:0]         w_rs;
  logic [31:0]         w_rt;
  logic [31:0]         w_sext;
  logic [31:0]         w_zext;
  logic [31:0]         w_alu;
  logic                w_alu_class;
  logic [31:0]         w_result;
  logic [`WIDTH_T-1:0] w_tnew_mem;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic [31:0]         r_hi, w_hi_nxt;
  logic [31:0]         r_lo, w_lo_nxt;
  logic [31:0]         r_a, w_a_nxt;
  logic [31:0]         r_b, w_b_nxt;
  mdu_op_e             r_op, w_op_nxt;

  logic                w_mdu_op;
  mdu_op_e             w_op_dec;
  logic                w_start;
  logic                w_signed_mul;
  logic [63:0]         w_ext_a;
  logic [63:0]         w_ext_b;
  logic [63:0]         w_prod;
  logic [31:0]         w_b_safe;
  logic [31:0]         w_quo;
  logic [31:0]         w_rem;

  instr_t              r_instr_mem;
  logic [31:0]         r_pc_mem;
  logic [31:0]         r_alu_mem;
  logic [31:0]         r_rt_mem;
  logic [4:0]          r_wa_mem;
  logic [31:0]         r_wd_mem;
  logic [`WIDTH_T-1:0] r_tnew_mem;

  // Operand forwarding: MEM result wins over WB, register 0 never forwards.
  always_comb begin
    w_rs = bus.dataRs_EX;
    w_rt = bus.dataRt_EX;
    if (bus.regaddr_MEM == bus.addrRs_EX && bus.regaddr_MEM != 5'd0)
      w_rs = bus.regdata_MEM;
    else if (bus.regaddr_WB == bus.addrRs_EX && bus.regaddr_WB != 5'd0)
      w_rs = bus.regdata_WB;
    if (bus.regaddr_MEM == bus.addrRt_EX && bus.regaddr_MEM != 5'd0)
      w_rt = bus.regdata_MEM;
    else if (bus.regaddr_WB == bus.addrRt_EX && bus.regaddr_WB != 5'd0)
      w_rt = bus.regdata_WB;
  end

  assign w_sext = {{16{bus.imm16_EX[15]}}, bus.imm16_EX};
  assign w_zext = {16'h0000, bus.imm16_EX};

  // ALU: 32-bit wraparound arithmetic, logic, compares, shifts and address generation.
  always_comb begin
    w_alu       = 32'h0;
    w_alu_class = 1'b1;
    case (bus.instr_EX)
      I_ADD, I_ADDU:   w_alu = w_rs + w_rt;
      I_SUB, I_SUBU:   w_alu = w_rs - w_rt;
      I_AND:           w_alu = w_rs & w_rt;
      I_OR:            w_alu = w_rs | w_rt;
      I_XOR:           w_alu = w_rs ^ w_rt;
      I_NOR:           w_alu = ~(w_rs | w_rt);
      I_SLT:           w_alu = {31'h0, ($signed(w_rs) < $signed(w_rt))};
      I_SLTU:          w_alu = {31'h0, (w_rs < w_rt)};
      I_SLL:           w_alu = w_rt << bus.shamt_EX;
      I_SRL:           w_alu = w_rt >> bus.shamt_EX;
      I_SRA:           w_alu = 32'($signed(w_rt) >>> bus.shamt_EX);
      I_SLLV:          w_alu = w_rt << w_rs[4:0];
      I_SRLV:          w_alu = w_rt >> w_rs[4:0];
      I_SRAV:          w_alu = 32'($signed(w_rt) >>> w_rs[4:0]);
      I_ADDI, I_ADDIU: w_alu = w_rs + w_sext;
      I_SLTI:          w_alu = {31'h0, ($signed(w_rs) < $signed(w_sext))};
      I_SLTIU:         w_alu = {31'h0, (w_rs < w_sext)};
      I_ANDI:          w_alu = w_rs & w_zext;
      I_ORI:           w_alu = w_rs | w_zext;
      I_XORI:          w_alu = w_rs ^ w_zext;
      I_LW, I_LH, I_LHU, I_LB, I_LBU, I_SW, I_SH, I_SB: begin
        w_alu       = w_rs + w_sext;
        w_alu_class = 1'b0;
      end
      default:         w_alu_class = 1'b0;
    endcase
  end

  // Writeback value carried to MEM: ALU result, HI/LO, or the value ID already produced.
  always_comb begin
    w_result = bus.regWriteData_EX;
    if (w_alu_class)                 w_result = w_alu;
    else if (bus.instr_EX == I_MFHI) w_result = r_hi;
    else if (bus.instr_EX == I_MFLO) w_result = r_lo;
  end

  assign w_tnew_mem = (bus.Tnew_EX != '0) ? (bus.Tnew_EX - `WIDTH_T'(1)) : '0;

  // Forward pair back to ID is valid only once the EX result is ready.
  assign bus.regaddr_EXfwd = (bus.Tnew_EX == '0) ? bus.regWriteAddr_EX : 5'd0;
  assign bus.regdata_EXfwd = bus.regWriteData_EX;

  // MDU op decode; the accumulate family only starts the MDU when enabled.
  always_comb begin
    w_mdu_op = 1'b1;
    w_op_dec = M_MULT;
    case (bus.instr_EX)
      I_MULT:  w_op_dec = M_MULT;
      I_MULTU: w_op_dec = M_MULTU;
      I_DIV:   w_op_dec = M_DIV;
      I_DIVU:  w_op_dec = M_DIVU;
`ifdef MDU_MADD_EN
      I_MADD:  w_op_dec = M_MADD;
      I_MADDU: w_op_dec = M_MADDU;
      I_MSUB:  w_op_dec = M_MSUB;
      I_MSUBU: w_op_dec = M_MSUBU;
`endif
      default: w_mdu_op = 1'b0;
    endcase
  end

  assign w_start      = w_mdu_op && (r_state == S_IDLE) && !bus.clr && !reset;
  assign bus.mdu_busy = w_start || (r_state == S_BUSY);

  // Datapath on latched operands: 64-bit product and guarded divide.
  assign w_signed_mul = (r_op == M_MULT) || (r_op == M_MADD) || (r_op == M_MSUB);
  assign w_ext_a      = w_signed_mul ? {{32{r_a[31]}}, r_a} : {32'h0, r_a};
  assign w_ext_b      = w_signed_mul ? {{32{r_b[31]}}, r_b} : {32'h0, r_b};
  assign w_prod       = w_ext_a * w_ext_b;
  assign w_b_safe     = (r_b == 32'h0) ? 32'h1 : r_b;

  // Signed divide truncates toward zero; remainder follows the dividend's sign.
  always_comb begin
    if (r_op == M_DIV) begin
      w_quo = 32'($signed(r_a) / $signed(w_b_safe));
      w_rem = 32'($signed(r_a) % $signed(w_b_safe));
    end else begin
      w_quo = r_a / w_b_safe;
      w_rem = r_a % w_b_safe;
    end
  end

  // MDU next-state: start latches operands, BUSY counts down, count==1 commits HI/LO.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_a_nxt     = w_rs;
          w_b_nxt     = w_rt;
          w_op_nxt    = w_op_dec;
          w_count_nxt = ((w_op_dec == M_DIV) || (w_op_dec == M_DIVU)) ?
                        CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          w_state_nxt = S_BUSY;
        end else if (!bus.clr) begin
          if (bus.instr_EX == I_MTHI) w_hi_nxt = w_rs;
          if (bus.instr_EX == I_MTLO) w_lo_nxt = w_rs;
        end
      end
      S_BUSY: begin
        w_count_nxt = r_count - CNT_W'(1);
        if (r_count == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          case (r_op)
            M_MULT, M_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod;
            M_DIV, M_DIVU: begin
              if (r_b != 32'h0) begin
                w_lo_nxt = w_quo;
                w_hi_nxt = w_rem;
              end
            end
            M_MADD, M_MADDU: {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + w_prod;
            default:         {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} - w_prod;
          endcase
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // MDU state register; reset aborts any op and clears HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_hi    <= 32'h0;
      r_lo    <= 32'h0;
      r_a     <= 32'h0;
      r_b     <= 32'h0;
      r_op    <= M_MULT;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // EX/MEM pipeline register; reset or clr inserts a zero bubble.
  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      r_instr_mem <= I_NOP;
      r_pc_mem    <= 32'h0;
      r_alu_mem   <= 32'h0;
      r_rt_mem    <= 32'h0;
      r_wa_mem    <= 5'd0;
      r_wd_mem    <= 32'h0;
      r_tnew_mem  <= '0;
    end else begin
      r_instr_mem <= bus.instr_EX;
      r_pc_mem    <= bus.PC_EX;
      r_alu_mem   <= w_alu;
      r_rt_mem    <= w_rt;
      r_wa_mem    <= bus.regWriteAddr_EX;
      r_wd_mem    <= w_result;
      r_tnew_mem  <= w_tnew_mem;
    end
  end

  assign bus.instr_MEM        = r_instr_mem;
  assign bus.PC_MEM           = r_pc_mem;
  assign bus.aluOut_MEM       = r_alu_mem;
  assign bus.dataRt_MEM       = r_rt_mem;
  assign bus.regWriteAddr_MEM = r_wa_mem;
  assign bus.regWriteData_MEM = r_wd_mem;
  assign bus.Tnew_MEM         = r_tnew_mem;

endmodule

// File: tb/tb_ex_level.sv
// Directed bench for ex_level: scoreboard of expected EX/MEM contents plus MDU timing checks.

module tb_ex_level;
  import ex_level_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  ex_level_if bus();

  ex_level #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic [1:0]  tn;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    instr_t      ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic [31:0] wd_in;
    logic [31:0] alu;
    logic [31:0] wd;
  } vec_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input instr_t ins, input logic [31:0] drs, input logic [31:0] drt,
                       input logic [15:0] imm, input logic [4:0] sh, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [1:0] tn);
    bus.instr_EX        = ins;
    bus.PC_EX           = 32'h0000_3000;
    bus.dataRs_EX       = drs;
    bus.dataRt_EX       = drt;
    bus.imm16_EX        = imm;
    bus.shamt_EX        = sh;
    bus.addrRs_EX       = 5'd1;
    bus.addrRt_EX       = 5'd2;
    bus.regWriteAddr_EX = wa;
    bus.regWriteData_EX = wd;
    bus.Tnew_EX         = tn;
  endtask

  task automatic nop();
    drive(I_NOP, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 32'h0, 2'd0);
  endtask

  task automatic push(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                      input logic [4:0] wa, input logic [1:0] tn);
    exp_t e;
    e.tag = tag; e.alu = alu; e.wd = wd; e.wa = wa; e.tn = tn;
    sb.push_back(e);
  endtask

  // One clock; compares EX/MEM against the scoreboard when an entry is waiting.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".alu"}, bus.aluOut_MEM, e.alu);
      chk({e.tag, ".wd"},  bus.regWriteData_MEM, e.wd);
      chk({e.tag, ".wa"},  32'(bus.regWriteAddr_MEM), 32'(e.wa));
      chk({e.tag, ".tn"},  32'(bus.Tnew_MEM), 32'(e.tn));
    end
  endtask

  // Counts busy cycles from the start cycle until the MDU goes idle, bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int k = 0; k < 40 && bus.mdu_busy; k++) begin
      cnt++;
      tick();
      nop();
      #1;
    end
  endtask

  vec_t vt[9];
  int   busy_cnt;

  initial begin
    vt[0] = '{I_SLT,   32'hFFFF_FFFF, 32'h1,         16'h0,    5'd0, 32'h0,  32'h1,         32'h1};
    vt[1] = '{I_SLTU,  32'hFFFF_FFFF, 32'h1,         16'h0,    5'd0, 32'h0,  32'h0,         32'h0};
    vt[2] = '{I_SRA,   32'h0,         32'h8000_0000, 16'h0,    5'd4, 32'h0,  32'hF800_0000, 32'hF800_0000};
    vt[3] = '{I_SRLV,  32'd36,        32'h8000_0000, 16'h0,    5'd0, 32'h0,  32'h0800_0000, 32'h0800_0000};
    vt[4] = '{I_NOR,   32'h0F0F_0000, 32'h00F0_000F, 16'h0,    5'd0, 32'h0,  32'hF000_FFF0, 32'hF000_FFF0};
    vt[5] = '{I_ADDIU, 32'h0,         32'h0,         16'hFFFF, 5'd0, 32'h0,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[6] = '{I_ORI,   32'h1,         32'h0,         16'h8000, 5'd0, 32'h0,  32'h0000_8001, 32'h0000_8001};
    vt[7] = '{I_LW,    32'h1000,      32'h0,         16'hFFFC, 5'd0, 32'h55, 32'h0000_0FFC, 32'h55};
    vt[8] = '{I_SUB,   32'd3,         32'd5,         16'h0,    5'd0, 32'h0,  32'hFFFF_FFFE, 32'hFFFF_FFFE};

    reset = 1'b1;
    bus.clr = 1'b0;
    bus.regaddr_MEM = 5'd0; bus.regdata_MEM = 32'h0;
    bus.regaddr_WB  = 5'd0; bus.regdata_WB  = 32'h0;
    drive(I_ADDU, 32'h1234, 32'h1, 16'h0, 5'd0, 5'd3, 32'h0, 2'd1);
    tick(); tick();
    chk("rst.alu", bus.aluOut_MEM, 32'h0);
    chk("rst.wd", bus.regWriteData_MEM, 32'h0);
    chk("rst.pc", bus.PC_MEM, 32'h0);
    chk("rst.instr", 32'(bus.instr_MEM), 32'h0);
    chk("rst.busy", 32'(bus.mdu_busy), 32'h0);
    reset = 1'b0;

    // ADDU wraps into the sign bit, no trap.
    drive(I_ADDU, 32'h7FFF_FFFF, 32'h1, 16'h0, 5'd0, 5'd3, 32'h0, 2'd1);
    push("addu", 32'h8000_0000, 32'h8000_0000, 5'd3, 2'd0);
    tick();
    chk("addu.pc", bus.PC_MEM, 32'h0000_3000);

    // Forward priority on rs: MEM over WB, then WB once MEM is $0.
    drive(I_ADDU, 32'd5, 32'h0, 16'h0, 5'd0, 5'd4, 32'h0, 2'd1);
    bus.addrRs_EX = 5'd3; bus.addrRt_EX = 5'd0;
    bus.regaddr_MEM = 5'd3; bus.regdata_MEM = 32'd7;
    bus.regaddr_WB  = 5'd3; bus.regdata_WB  = 32'd9;
    push("fwd_mem", 32'd7, 32'd7, 5'd4, 2'd0);
    tick();
    drive(I_ADDU, 32'd5, 32'h0, 16'h0, 5'd0, 5'd4, 32'h0, 2'd1);
    bus.addrRs_EX = 5'd3; bus.addrRt_EX = 5'd0;
    bus.regaddr_MEM = 5'd0;
    push("fwd_wb", 32'd9, 32'd9, 5'd4, 2'd0);
    tick();
    // Forward on rt from WB, visible as store data.
    drive(I_SW, 32'h100, 32'h11, 16'h4, 5'd0, 5'd0, 32'h0, 2'd0);
    bus.addrRs_EX = 5'd1; bus.addrRt_EX = 5'd2;
    bus.regaddr_WB = 5'd2; bus.regdata_WB = 32'h20;
    push("sw", 32'h104, 32'h0, 5'd0, 2'd0);
    tick();
    chk("sw.rtfwd", bus.dataRt_MEM, 32'h20);
    bus.regaddr_WB = 5'd0;

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].ins, vt[i].a, vt[i].b, vt[i].imm, vt[i].sh, 5'd8, vt[i].wd_in, 2'd1);
      push($sformatf("alu%0d", i), vt[i].alu, vt[i].wd, 5'd8, 2'd0);
      tick();
    end

    // MULT: busy six cycles counting the start cycle.
    drive(I_MULT, 32'hFFFF_FFFE, 32'd3, 16'h0, 5'd0, 5'd0, 32'h0, 2'd0);
    #1;
    count_busy(busy_cnt);
    chk("mult.busy", 32'(busy_cnt), 32'd6);
    drive(I_MFHI, 32'h0, 32'h0, 16'h0, 5'd0, 5'd9, 32'h0, 2'd1);
    push("mult.hi", 32'h0, 32'hFFFF_FFFF, 5'd9, 2'd0);
    tick();
    drive(I_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd9, 32'h0, 2'd1);
    push("mult.lo", 32'h0, 32'hFFFF_FFFA, 5'd9, 2'd0);
    tick();

    // DIV -7/2 truncates toward zero.
    drive(I_DIV, 32'hFFFF_FFF9, 32'd2, 16'h0, 5'd0, 5'd0, 32'h0, 2'd0);
    #1;
    count_busy(busy_cnt);
    chk("div.busy", 32'(busy_cnt), 32'd11);
    drive(I_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd9, 32'h0, 2'd1);
    push("div.lo", 32'h0, 32'hFFFF_FFFD, 5'd9, 2'd0);
    tick();
    drive(I_MFHI, 32'h0, 32'h0, 16'h0, 5'd0, 5'd9, 32'h0, 2'd1);
    push("div.hi", 32'h0, 32'hFFFF_FFFF, 5'd9, 2'd0);
    tick();

    // DIVU by zero keeps HI/LO and normal busy length.
    drive(I_DIVU, 32'd5, 32'd0, 16'h0, 5'd0, 5'd0, 32'h0, 2'd0);
    #1;
    count_busy(busy_cnt);
    chk("div0.busy", 32'(busy_cnt), 32'd11);
    drive(I_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd9, 32'h0, 2'd1);
    push("div0.lo", 32'h0, 32'hFFFF_FFFD, 5'd9, 2'd0);
    tick();
    drive(I_MFHI, 32'h0, 32'h0, 16'h0, 5'd0, 5'd9, 32'h0, 2'd1);
    push("div0.hi", 32'h0, 32'hFFFF_FFFF, 5'd9, 2'd0);
    tick();

    // MTHI writes HI; MTLO under clr is dropped and the bubble zeroes EX/MEM.
    drive(I_MTHI, 32'h1234, 32'h0, 16'h0, 5'd0, 5'd0, 32'h0, 2'd0);
    tick();
    drive(I_MTLO, 32'hAAAA, 32'h0, 16'h0, 5'd0, 5'd0, 32'h0, 2'd0);
    bus.clr = 1'b1;
    push("clr", 32'h0, 32'h0, 5'd0, 2'd0);
    tick();
    bus.clr = 1'b0;
    drive(I_MFHI, 32'h0, 32'h0, 16'h0, 5'd0, 5'd9, 32'h0, 2'd1);
    push("mthi", 32'h0, 32'h1234, 5'd9, 2'd0);
    tick();
    drive(I_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd9, 32'h0, 2'd1);
    push("mtlo_clr", 32'h0, 32'hFFFF_FFFD, 5'd9, 2'd0);
    tick();

    // Reset during cycle 3 of a DIV aborts it and clears HI/LO.
    drive(I_DIV, 32'd100, 32'd7, 16'h0, 5'd0, 5'd0, 32'h0, 2'd0);
    #1;
    chk("div2.start", 32'(bus.mdu_busy), 32'h1);
    tick(); nop(); tick();
    reset = 1'b1;
    drive(I_ADDU, 32'h5, 32'h6, 16'h0, 5'd0, 5'd3, 32'h0, 2'd1);
    push("rst_mid", 32'h0, 32'h0, 5'd0, 2'd0);
    tick();
    chk("rst_mid.busy", 32'(bus.mdu_busy), 32'h0);
    chk("rst_mid.instr", 32'(bus.instr_MEM), 32'h0);
    reset = 1'b0;
    drive(I_MFHI, 32'h0, 32'h0, 16'h0, 5'd0, 5'd9, 32'h0, 2'd1);
    push("rst_mid.hi", 32'h0, 32'h0, 5'd9, 2'd0);
    tick();
    drive(I_MFLO, 32'h0, 32'h0, 16'h0, 5'd0, 5'd9, 32'h0, 2'd1);
    push("rst_mid.lo", 32'h0, 32'h0, 5'd9, 2'd0);
    tick();

    // JAL forwarding: ready now vs. two cycles away.
    drive(I_JAL, 32'h0, 32'h0, 16'h0, 5'd0, 5'd31, 32'h3008, 2'd0);
    #1;
    chk("jal.fwda", 32'(bus.regaddr_EXfwd), 32'd31);
    chk("jal.fwdd", bus.regdata_EXfwd, 32'h3008);
    push("jal", 32'h0, 32'h3008, 5'd31, 2'd0);
    tick();
    drive(I_JAL, 32'h0, 32'h0, 16'h0, 5'd0, 5'd31, 32'h3008, 2'd2);
    #1;
    chk("jal2.fwda", 32'(bus.regaddr_EXfwd), 32'd0);
    push("jal2", 32'h0, 32'h3008, 5'd31, 2'd1);
    tick();

    // MADD only reaches the MDU when the accumulate feature is built in.
    drive(I_MADD, 32'd2, 32'd3, 16'h0, 5'd0, 5'd0, 32'h0, 2'd0);
    #1;
`ifdef MDU_MADD_EN
    chk("madd.busy", 32'(bus.mdu_busy), 32'h1);
`else
    chk("madd.busy", 32'(bus.mdu_busy), 32'h0);
`endif
    tick();
    chk("madd.pass", 32'(bus.instr_MEM), 32'(I_MADD));
    nop();
    for (int k = 0; k < 10; k++) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
